multicycle_ctrl_fsm: RTL and testbench

Multicycle control state machine for the MIPS core. It sequences the shared ALU, unified memory port, instruction register, PC and register file across 3–5 cycles per instruction, replacing the single-cycle decode path. It supports lw, sw, beq, R-type (add/sub/and/or/slt), addi and andi. A memory-ready handshake with a bounded wait counter sits on every memory state.

---
 rtl/multicycle_ctrl_fsm.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Purpose  : Multicycle MIPS control unit. Sequences the shared ALU, unified
//             memory port, IR, PC and register file over 3-5 cycles per
//             instruction (lw, sw, beq, R-type add/sub/and/or/slt, addi,
//             andi). Every memory state has a mem_ready handshake with a
//             bounded wait counter (MAX_WAIT, 0 = no timeout).
//  Ports    : clk, reset (async, active-high)
//             opcode/funct/zero/mem_ready        - decode and handshake inputs
//             mem_req/memWrite/IorD              - memory port control
//             IRWrite/PCWrite/Branch/PCEn/PCSrc  - IR and PC control
//             RegWrite/regDST/memToReg           - register file control
//             ALUSrcA/ALUSrcB/ALUControl         - datapath ALU control
//             instr_done/illegal/mem_timeout     - single-cycle status pulses
//             state                              - current state, for debug
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       PCEn,
    output logic       RegWrite,
    output logic       regDST,
    output logic       memToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       PCSrc,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_IMMEX    = 4'd9,
        ST_IMMWB    = 4'd10
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;

    localparam int              c_CW  = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_WAIT);

    state_t          r_state;
    state_t          w_next;
    logic [c_CW-1:0] r_wait;

    logic       w_req, w_we, w_iord, w_ir, w_pcw, w_br, w_rw, w_dst, w_m2r;
    logic       w_srca, w_pcsrc, w_done, w_ill;
    logic [1:0] w_srcb;
    logic [2:0] w_aluc;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;
    logic       w_mem_state, w_timeout, w_stall;

    // Memory states are identified from the state register directly so the
    // timeout term does not feed back through the output decode below.
    assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEMREAD) ||
                         (r_state == ST_MEMWRITE);
    // Timeout only fires while mem_ready is low, so a late ready always wins.
    assign w_timeout   = (MAX_WAIT != 0) && w_mem_state && !mem_ready &&
                         (r_wait == c_MAX);
    assign w_stall     = w_mem_state && !mem_ready && !w_timeout;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = 3'b010;
        case (funct)
            6'b100000: w_funct_alu = 3'b010;
            6'b100010: w_funct_alu = 3'b110;
            6'b100100: w_funct_alu = 3'b000;
            6'b100101: w_funct_alu = 3'b001;
            6'b101010: w_funct_alu = 3'b111;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next  = ST_FETCH;
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_iord  = 1'b0;
        w_ir    = 1'b0;
        w_pcw   = 1'b0;
        w_br    = 1'b0;
        w_rw    = 1'b0;
        w_dst   = 1'b0;
        w_m2r   = 1'b0;
        w_srca  = 1'b0;
        w_srcb  = 2'b00;
        w_aluc  = 3'b010;
        w_pcsrc = 1'b0;
        w_done  = 1'b0;
        w_ill   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_req  = 1'b1;
                w_srcb = 2'b01;
                w_ir   = mem_ready;
                w_pcw  = mem_ready;
                w_next = mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                w_srcb = 2'b11;
                case (opcode)
                    c_OP_LW, c_OP_SW:     w_next = ST_MEMADR;
                    c_OP_BEQ:             w_next = ST_BRANCH;
                    c_OP_ADDI, c_OP_ANDI: w_next = ST_IMMEX;
                    c_OP_RTYPE: begin
                        if (w_funct_ok) begin
                            w_next = ST_EXECUTE;
                        end else begin
                            w_ill  = 1'b1;
                            w_done = 1'b1;
                        end
                    end
                    default: begin
                        w_ill  = 1'b1;
                        w_done = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                w_srca = 1'b1;
                w_srcb = 2'b10;
                w_next = (opcode == c_OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                w_req  = 1'b1;
                w_iord = 1'b1;
                if (mem_ready) begin
                    w_next = ST_MEMWB;
                end else if (w_timeout) begin
                    w_done = 1'b1;
                end else begin
                    w_next = ST_MEMREAD;
                end
            end
            ST_MEMWB: begin
                w_rw   = 1'b1;
                w_m2r  = 1'b1;
                w_done = 1'b1;
            end
            ST_MEMWRITE: begin
                w_req  = 1'b1;
                w_iord = 1'b1;
                w_we   = !w_timeout;
                if (mem_ready || w_timeout) begin
                    w_done = 1'b1;
                end else begin
                    w_next = ST_MEMWRITE;
                end
            end
            ST_EXECUTE: begin
                w_srca = 1'b1;
                w_aluc = w_funct_alu;
                w_next = ST_ALUWB;
            end
            ST_ALUWB: begin
                w_rw   = 1'b1;
                w_dst  = 1'b1;
                w_done = 1'b1;
            end
            ST_BRANCH: begin
                w_srca  = 1'b1;
                w_aluc  = 3'b110;
                w_pcsrc = 1'b1;
                w_br    = 1'b1;
                w_done  = 1'b1;
            end
            ST_IMMEX: begin
                w_srca = 1'b1;
                w_srcb = 2'b10;
                w_aluc = (opcode == c_OP_ANDI) ? 3'b000 : 3'b010;
                w_next = ST_IMMWB;
            end
            ST_IMMWB: begin
                w_rw   = 1'b1;
                w_done = 1'b1;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    // The wait counter is zero whenever the FSM is not stalled in a memory
    // state, so every entry into a memory state (including FETCH re-entry
    // after a timeout) starts counting from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (w_stall) begin
                if (r_wait != c_MAX) begin
                    r_wait <= r_wait + 1'b1;
                end
            end else begin
                r_wait <= '0;
            end
        end
    end

    // Strobes and pulses are held low while reset is asserted, because the
    // reset state (FETCH) would otherwise request memory immediately.
    assign mem_req     = w_req   & ~reset;
    assign memWrite    = w_we    & ~reset;
    assign IRWrite     = w_ir    & ~reset;
    assign PCWrite     = w_pcw   & ~reset;
    assign Branch      = w_br    & ~reset;
    assign RegWrite    = w_rw    & ~reset;
    assign instr_done  = w_done  & ~reset;
    assign illegal     = w_ill   & ~reset;
    assign mem_timeout = w_timeout & ~reset;
    assign PCEn        = PCWrite | (Branch & zero);

    assign IorD        = w_iord;
    assign regDST      = w_dst;
    assign memToReg    = w_m2r;
    assign ALUSrcA     = w_srca;
    assign ALUSrcB     = w_srcb;
    assign ALUControl  = w_aluc;
    assign PCSrc       = w_pcsrc;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl_fsm
//  Purpose  : Directed self-checking bench for multicycle_ctrl_fsm with
//             MAX_WAIT = 4. Inputs change and outputs are sampled during the
//             low clock phase, one clock per step.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_ANDI = 6'b001100;
    localparam logic [5:0] c_RT   = 6'b000000;
    localparam logic [5:0] c_BAD  = 6'b111111;

    logic       clk;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_req, memWrite, IorD, IRWrite, PCWrite, Branch, PCEn;
    logic       RegWrite, regDST, memToReg, ALUSrcA, PCSrc;
    logic       instr_done, illegal, mem_timeout;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    multicycle_ctrl_fsm #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .memWrite(memWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch), .PCEn(PCEn),
        .RegWrite(RegWrite), .regDST(regDST), .memToReg(memToReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .PCSrc(PCSrc), .instr_done(instr_done), .illegal(illegal),
        .mem_timeout(mem_timeout), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; apply mem_ready for the new cycle and let outputs settle.
    task automatic step(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; opcode = c_LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcen", PCEn, 0);

        // lw, zero-wait memory: 0,1,2,3,4,0
        reset = 1'b0; #1;
        chk("lw_f_state", state, 0);
        chk("lw_f_req", mem_req, 1);
        chk("lw_f_irw", IRWrite, 1);
        chk("lw_f_pcen", PCEn, 1);
        chk("lw_f_srcb", ALUSrcB, 2'b01);
        step(1); chk("lw_d_state", state, 1); chk("lw_d_srcb", ALUSrcB, 2'b11); chk("lw_d_req", mem_req, 0);
        step(1); chk("lw_a_state", state, 2); chk("lw_a_srca", ALUSrcA, 1); chk("lw_a_srcb", ALUSrcB, 2'b10);
        step(1); chk("lw_r_state", state, 3); chk("lw_r_req", mem_req, 1); chk("lw_r_iord", IorD, 1);
        chk("lw_r_done", instr_done, 0);
        step(1); chk("lw_wb_state", state, 4); chk("lw_wb_rw", RegWrite, 1); chk("lw_wb_m2r", memToReg, 1);
        chk("lw_wb_done", instr_done, 1);
        step(1); chk("lw_end_state", state, 0); chk("lw_end_done", instr_done, 0);

        // sw with three wait cycles in MEMWRITE
        opcode = c_SW;
        step(1); chk("sw_d_state", state, 1);
        step(1); chk("sw_a_state", state, 2);
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("sw_wait_state", state, 5);
            chk("sw_wait_we", memWrite, 1);
            chk("sw_wait_done", instr_done, 0);
            chk("sw_wait_rw", RegWrite, 0);
        end
        step(1); chk("sw_last_state", state, 5); chk("sw_last_we", memWrite, 1); chk("sw_last_done", instr_done, 1);
        step(1); chk("sw_end_state", state, 0); chk("sw_end_rw", RegWrite, 0);

        // R-type sub then slt
        opcode = c_RT; funct = 6'b100010;
        step(1); chk("sub_d_state", state, 1);
        step(1); chk("sub_ex_state", state, 6); chk("sub_ex_aluc", ALUControl, 3'b110);
        chk("sub_ex_srca", ALUSrcA, 1); chk("sub_ex_srcb", ALUSrcB, 2'b00);
        step(1); chk("sub_wb_state", state, 7); chk("sub_wb_dst", regDST, 1); chk("sub_wb_rw", RegWrite, 1);
        chk("sub_wb_done", instr_done, 1);
        funct = 6'b101010;
        step(1); chk("slt_f_state", state, 0);
        step(1); step(1); chk("slt_ex_aluc", ALUControl, 3'b111);
        step(1); chk("slt_wb_state", state, 7);

        // beq taken then not taken, three cycles each
        opcode = c_BEQ; zero = 1'b1;
        step(1); chk("beq1_f_state", state, 0);
        step(1); chk("beq1_d_state", state, 1);
        step(1); chk("beq1_b_state", state, 8); chk("beq1_pcen", PCEn, 1); chk("beq1_pcsrc", PCSrc, 1);
        chk("beq1_aluc", ALUControl, 3'b110); chk("beq1_done", instr_done, 1);
        zero = 1'b0; #1;
        chk("beq0_pcen", PCEn, 0); chk("beq0_branch", Branch, 1);
        step(1); chk("beq2_f_state", state, 0);
        step(1); step(1); chk("beq2_b_state", state, 8); chk("beq2_pcen", PCEn, 0);

        // addi then andi
        opcode = c_ADDI;
        step(1); step(1); step(1);
        chk("addi_ex_state", state, 9); chk("addi_aluc", ALUControl, 3'b010); chk("addi_srcb", ALUSrcB, 2'b10);
        step(1); chk("addi_wb_state", state, 10); chk("addi_wb_rw", RegWrite, 1); chk("addi_wb_dst", regDST, 0);
        opcode = c_ANDI;
        step(1); step(1); step(1);
        chk("andi_ex_state", state, 9); chk("andi_aluc", ALUControl, 3'b000);
        step(1); chk("andi_wb_state", state, 10);

        // Illegal opcode and unsupported funct: two cycles each
        opcode = c_BAD;
        step(1); chk("ill_f_state", state, 0);
        step(1); chk("ill_d_state", state, 1); chk("ill_pulse", illegal, 1); chk("ill_done", instr_done, 1);
        opcode = c_RT; funct = 6'b000000;
        step(1); chk("illf_f_state", state, 0);
        step(1); chk("illf_pulse", illegal, 1);

        // FETCH timeout: four waiting cycles, timeout in the fifth, FETCH re-entered
        step(0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(0);
            chk("to_wait_state", state, 0);
            chk("to_wait_flag", mem_timeout, 0);
            chk("to_wait_irw", IRWrite, 0);
        end
        step(0); chk("to_fire", mem_timeout, 1); chk("to_fire_irw", IRWrite, 0); chk("to_fire_state", state, 0);
        for (int i = 0; i < 4; i++) begin
            step(0);
            chk("to_reent_flag", mem_timeout, 0);
        end
        // counter is at MAX_WAIT here: a late ready must win over the timeout
        opcode = c_LW;
        step(1); chk("to_ready_wins", mem_timeout, 0); chk("to_ready_irw", IRWrite, 1);

        // MEMREAD timeout aborts lw with instr_done, no writeback
        step(1); step(1); chk("lwto_a_state", state, 2);
        for (int i = 0; i < 4; i++) step(0);
        chk("lwto_wait_flag", mem_timeout, 0);
        step(0); chk("lwto_fire", mem_timeout, 1); chk("lwto_done", instr_done, 1); chk("lwto_state", state, 3);
        step(1); chk("lwto_end_state", state, 0); chk("lwto_end_rw", RegWrite, 0);

        // Reset mid-MEMREAD
        step(1); step(1); step(0); chk("rmid_pre_state", state, 3);
        reset = 1'b1; #1;
        chk("rmid_state", state, 0); chk("rmid_req", mem_req, 0);
        @(negedge clk); #1;
        chk("rmid_hold_req", mem_req, 0); chk("rmid_hold_rw", RegWrite, 0);
        reset = 1'b0; mem_ready = 1'b1; #1;
        chk("rmid_rel_state", state, 0); chk("rmid_rel_req", mem_req, 1);
        step(1); chk("rmid_dec_state", state, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
